multi_freq_div: RTL and testbench
=================================

// Module: multi_freq_div
// PURPOSE
//   Parametrised, run-time programmable multi-channel clock/tick divider. Successor to the
//   fixed two-output divider that generates the slow 1 Hz / 2 Hz rates.
//   From the single system clock it produces NUM_CH independent 50% duty square waves plus
//   one-cycle tick strobes. Parking timers, blink logic and display scan consume these.
//   Channels can be reprogrammed, frozen and phase-aligned at run time.
// PARAMETERS
//   NUM_CH     4   number of output channels (1..16)
//   CNT_W      32  width of each half-period counter and divisor register
//   BASE_HALF  2   reset half-period of ch0 in clk cycles. Channel c resets to BASE_HALF<<c.
//                  Each channel is therefore half the frequency of the one below it.
// PORTS
//   clk        in   1                 system clock, rising edge
//   reset      in   1                 asynchronous, active-low reset
//   en         in   1                 global count enable; 0 freezes all counters and outputs
//   sync       in   1                 1-cycle strobe: restart all channels in phase
//   cfg_we     in   1                 write strobe for a channel half-period
//   cfg_ch     in   $clog2(NUM_CH)    channel index for cfg_we (min width 1)
//   cfg_half   in   CNT_W             new half-period in clk cycles; 0 disables the channel
//   clk_out    out  NUM_CH            per-channel square wave, period 2*half clk cycles
//   tick       out  NUM_CH            per-channel 1-cycle strobe on each 0->1 of clk_out
// BEHAVIOUR
//   - Reset (reset==0, asynchronous, no clock edge needed):
//     - clk_out=0, tick=0, all counters=0.
//     - half[c]=BASE_HALF<<c, truncated to CNT_W.
//   - All outputs are registered. There is no combinational path from any input to any output.
//   - Per channel c, on each rising clk with en=1, sync=0, and no write to c:
//     - half[c]==0: cnt=0, clk_out[c]=0, tick[c]=0 (channel disabled).
//     - cnt==half[c]-1: cnt<=0, clk_out[c]<=~clk_out[c], tick[c]<=~clk_out[c].
//     - otherwise: cnt<=cnt+1, tick[c]<=0.
//   - Timing consequences:
//     - First 0->1 of clk_out[c] occurs on the half[c]-th enabled edge after reset release.
//     - half=1 toggles every edge, giving a period of 2 clk cycles.
//     - tick[c] is high in exactly the cycle in which clk_out[c] first reads 1.
//   - en=0:
//     - cnt and clk_out hold; tick is forced to 0.
//     - When en returns to 1, counting resumes with phase intact.
//   - cfg_we=1 with cfg_ch<NUM_CH, on the clock edge:
//     - half[cfg_ch]<=cfg_half.
//     - That channel's cnt<=0, clk_out<=0, tick<=0.
//     - The write takes effect regardless of en.
//     - Other channels are unaffected.
//   - cfg_we with cfg_ch>=NUM_CH is ignored; no state changes.
//   - sync=1, on the clock edge, regardless of en:
//     - every cnt<=0, clk_out<=0, tick<=0; half registers are unchanged.
//     - All enabled channels then rise together half[c] edges later.
//   - sync and cfg_we in the same cycle:
//     - both take effect: the half register is written and all channels restart.
//   - Writing the current value to a channel still restarts it. Software uses this for
//     per-channel phase reset.
//   - No internal state other than cnt, clk_out, tick and half per channel.
// TESTING (clk period 25 ns; NUM_CH=4, CNT_W=32, BASE_HALF=2 unless stated)
//   1. reset low 50 ns, then high; en=1 ->
//      - clk_out[0..3] periods are 4/8/16/32 clk.
//      - clk_out[0] first reads 1 after the 2nd edge.
//      - tick[c] is exactly 1 cycle wide at each rise and never at falls.
//   2. Mid-run, cfg_we with ch=1, half=3 ->
//      - clk_out[1]=0 on the next edge; it then rises 3 edges later with period 6.
//      - ch0, ch2 and ch3 show no glitch or phase shift.
//   3. ch2 half=0 -> clk_out[2] and tick[2] stuck at 0. Then ch2 half=1 -> clk_out[2] toggles
//      every edge, with tick[2] on alternate cycles.
//   4. en=0 for 7 cycles mid-period ->
//      - outputs frozen and tick=0 throughout.
//      - After en=1, the remaining count to the toggle equals the count remaining before the
//        freeze.
//   5. 1-cycle sync with different halves loaded ->
//      - all clk_out=0 next edge; all channels rise on edges 2/4/8/16 after sync.
//      - Repeat with sync+cfg_we(ch0, half=5) in the same cycle -> ch0 rises 5 edges later.
//   6. Assert reset between clock edges while clk_out=4'b1111 ->
//      - outputs clear immediately, before the next edge.
//      - Halves return to 2/4/8/16; a cfg_we with cfg_ch=3 during reset has no effect.

Source files
------------

// File: rtl/multi_freq_div.sv
// Run-time programmable multi-channel divider: NUM_CH independent 50% duty square waves
// with a one-cycle tick on every rising output edge. Channels can be rewritten, frozen or re-phased.
module multi_freq_div #(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32,
  parameter int BASE_HALF = 2,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(BASE_HALF) << c;

    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_tick;
    logic             w_wr;

    // An out-of-range channel index never matches, so such writes are dropped.
    assign w_wr = cfg_we && (cfg_ch == CH_W'(c));

    // A write or sync restarts the channel even while counting is frozen.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_half <= RST_HALF;
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_wr || sync) begin
        if (w_wr) begin
          r_half <= cfg_half;
        end
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else if (!en) begin
        r_tick <= 1'b0;
      end else if (r_half == '0) begin
        r_cnt  <= '0;
        r_out  <= 1'b0;
        r_tick <= 1'b0;
      end else if (r_cnt == r_half - CNT_W'(1)) begin
        r_cnt  <= '0;
        r_out  <= ~r_out;
        r_tick <= ~r_out;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end
    end

    assign clk_out[c] = r_out;
    assign tick[c]    = r_tick;
  end

endmodule

// File: tb/tb_multi_freq_div.sv
// Randomised and directed bench for multi_freq_div, checked against an edge-counting model:
// each channel's output is derived from how many enabled edges have passed since its last restart.
`timescale 1ns/1ps
module tb_multi_freq_div;

  localparam int NUM_CH    = 4;
  localparam int CNT_W     = 32;
  localparam int BASE_HALF = 2;

  logic              clk;
  logic              reset;
  logic              en;
  logic              sync;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [CNT_W-1:0]  cfg_half;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;

  int compared   = 0;
  int mismatched = 0;

  longint            mHalf  [NUM_CH];
  longint            mEdges [NUM_CH];
  logic [NUM_CH-1:0] mTick;
  logic              mWr;

  multi_freq_div #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .BASE_HALF(BASE_HALF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .sync(sync),
    .cfg_we(cfg_we),
    .cfg_ch(cfg_ch),
    .cfg_half(cfg_half),
    .clk_out(clk_out),
    .tick(tick)
  );

  initial begin
    clk = 1'b0;
    forever #12.5 clk = ~clk;
  end

  // Reference model: count enabled edges since the channel last restarted.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mHalf[c]  = longint'(BASE_HALF) << c;
        mEdges[c] = 0;
        mTick[c]  = 1'b0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        mWr = cfg_we && (cfg_ch == c);
        if (mWr) mHalf[c] = longint'(cfg_half);
        if (mWr || sync) begin
          mEdges[c] = 0;
          mTick[c]  = 1'b0;
        end else if (!en) begin
          mTick[c] = 1'b0;
        end else if (mHalf[c] == 0) begin
          mEdges[c] = 0;
          mTick[c]  = 1'b0;
        end else begin
          mEdges[c] = mEdges[c] + 1;
          mTick[c]  = (mEdges[c] % (2 * mHalf[c])) == mHalf[c];
        end
      end
    end
  end

  function automatic logic [NUM_CH-1:0] expOut();
    logic [NUM_CH-1:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mHalf[c] != 0) v[c] = ((mEdges[c] / mHalf[c]) % 2) == 1;
    end
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [NUM_CH-1:0] observed,
                             input logic [NUM_CH-1:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then compare on the falling edge.
  task automatic applyStimulus(input logic e, input logic s, input logic w,
                               input logic [1:0] ch, input logic [CNT_W-1:0] h);
    en       = e;
    sync     = s;
    cfg_we   = w;
    cfg_ch   = ch;
    cfg_half = h;
    @(posedge clk);
    @(negedge clk);
    checkOutput("clk_out", clk_out, expOut());
    checkOutput("tick", tick, mTick);
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0);
  endtask

  initial begin
    reset    = 1'b0;
    en       = 1'b1;
    sync     = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = 2'd0;
    cfg_half = '0;

    #20;
    checkOutput("reset_clk_out", clk_out, 4'b0000);
    checkOutput("reset_tick", tick, 4'b0000);
    #30;
    reset = 1'b1;

    // Power-up rates 4/8/16/32 cycles; ch0 rises on the 2nd edge.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0);
    checkOutput("edge1_clk_out", clk_out, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, '0);
    checkOutput("edge2_clk_out", clk_out, 4'b0001);
    checkOutput("edge2_tick", tick, 4'b0001);
    runIdle(80);

    // Reprogram ch1 mid-run.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 32'd3);
    runIdle(30);

    // Disable ch2, then run it at the fastest rate.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 32'd0);
    runIdle(10);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 32'd1);
    runIdle(10);

    // Freeze for 7 cycles.
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, '0);
    runIdle(20);

    // Phase-align with distinct halves, then sync combined with a write.
    for (int c = 0; c < NUM_CH; c++) applyStimulus(1'b1, 1'b0, 1'b1, 2'(c), 32'd2 << c);
    runIdle(5);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, '0);
    checkOutput("sync_clear", clk_out, 4'b0000);
    runIdle(40);
    applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 32'd5);
    runIdle(20);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                    $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
                    CNT_W'($urandom_range(0, 6)));
    end

    // Async reset while every output is high.
    for (int c = 0; c < NUM_CH; c++) applyStimulus(1'b1, 1'b0, 1'b1, 2'(c), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, '0);
    runIdle(3);
    checkOutput("all_high", clk_out, 4'b1111);
    #5;
    reset = 1'b0;
    #1;
    checkOutput("async_clr_clk_out", clk_out, 4'b0000);
    checkOutput("async_clr_tick", tick, 4'b0000);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 32'd7);
    cfg_we = 1'b0;
    reset  = 1'b1;
    runIdle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
